fadd_pipe: RTL and testbench

- Parametrised, handshaked IEEE-754 binary32 add/subtract unit; next generation of the fixed 3-stage fadd.
- Adds configurable latency, valid/ready flow control with global stall, per-operation add/sub select, a passthrough tag, and exception flags.
- Sits in the FPU execute path between the issue logic and the writeback arbiter.

---
 rtl/fadd_pipe.sv | 236 +++++++++++++++++++++++
 tb/tb_fadd_pipe.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_pipe.sv
// Pipelined binary32 add/subtract with valid/ready flow control, tag passthrough and exception flags.
// Optional accumulated flag register enabled by defining FADD_PIPE_STICKY_FLAGS_EN.
module fadd_pipe #(
    parameter int LATENCY = 3,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [31:0]      input_a,
    input  logic [31:0]      input_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] out_tag,
    output logic [2:0]       out_flags
`ifdef FADD_PIPE_STICKY_FLAGS_EN
    ,
    input  logic             flags_clr,
    output logic [2:0]       flags_sticky
`endif
);

    localparam int EXTRA = LATENCY - 3;
    localparam int PW    = TAG_W + 3 + 32;

    // Handshake: a transfer happens on an edge where valid and ready are both high.
    // Any stage holds while the output is valid but not accepted.
    logic stall, adv, accept;
    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // ---------------- stage 1: decode, order by magnitude, align ----------------
    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
    logic [7:0]  ea, eb, big_e, sml_e, dexp;
    logic [23:0] ma, mb, big_m, sml_m;
    logic        big_s, sml_s;
    logic [49:0] wide;
    logic [26:0] sml_al;
    logic        spec;
    logic [31:0] spec_res;
    logic [2:0]  spec_flags;

    always_comb begin
        sa    = input_a[31];
        sb    = input_b[31] ^ in_sub;
        ea    = input_a[30:23];
        eb    = input_b[30:23];
        ma    = (ea == 8'd0) ? 24'd0 : {1'b1, input_a[22:0]};
        mb    = (eb == 8'd0) ? 24'd0 : {1'b1, input_b[22:0]};
        a_nan = (ea == 8'hFF) && (input_a[22:0] != 23'd0);
        b_nan = (eb == 8'hFF) && (input_b[22:0] != 23'd0);
        a_inf = (ea == 8'hFF) && (input_a[22:0] == 23'd0);
        b_inf = (eb == 8'hFF) && (input_b[22:0] == 23'd0);
        swap  = {eb, mb} > {ea, ma};
        big_e = swap ? eb : ea;
        big_m = swap ? mb : ma;
        big_s = swap ? sb : sa;
        sml_e = swap ? ea : eb;
        sml_m = swap ? ma : mb;
        sml_s = swap ? sa : sb;
        dexp  = big_e - sml_e;
        wide  = {sml_m, 26'd0} >> dexp;
        // Shifts of 26+ leave nothing above the round bit; only a sticky remains.
        if (dexp >= 8'd26)
            sml_al = {26'd0, |sml_m};
        else
            sml_al = {wide[49:24], |wide[23:0]};
        spec       = 1'b0;
        spec_res   = 32'd0;
        spec_flags = 3'b000;
        if (a_nan || b_nan || (a_inf && b_inf && (sa ^ sb))) begin
            spec       = 1'b1;
            spec_res   = 32'h7FC0_0000;
            spec_flags = 3'b100;
        end else if (a_inf) begin
            spec     = 1'b1;
            spec_res = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            spec     = 1'b1;
            spec_res = {sb, 8'hFF, 23'd0};
        end
    end

    logic             s1_valid, s1_sign, s1_esub, s1_spec;
    logic [7:0]       s1_exp;
    logic [23:0]      s1_ma;
    logic [26:0]      s1_mb;
    logic [31:0]      s1_spec_res;
    logic [2:0]       s1_spec_flags;
    logic [TAG_W-1:0] s1_tag;

    // ---------------- stage 2: add/subtract and normalise ----------------
    logic [27:0]        sum28;
    logic [4:0]         lz;
    logic               found;
    logic [26:0]        norm;
    logic signed [9:0]  nexp;
    logic               nzero, nsign;

    always_comb begin
        if (s1_esub)
            sum28 = {1'b0, s1_ma, 3'b000} - {1'b0, s1_mb};
        else
            sum28 = {1'b0, s1_ma, 3'b000} + {1'b0, s1_mb};
        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum28[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end
        if (sum28[27]) begin
            norm = {sum28[27:2], sum28[1] | sum28[0]};
            nexp = $signed({2'b00, s1_exp}) + 10'sd1;
        end else begin
            norm = sum28[26:0] << lz;
            nexp = $signed({2'b00, s1_exp}) - $signed({5'd0, lz});
        end
        // Exact cancellation gives +0; like-signed zeros keep their sign.
        nzero = (sum28 == 28'd0);
        nsign = (nzero && s1_esub) ? 1'b0 : s1_sign;
    end

    logic              s2_valid, s2_sign, s2_zero, s2_spec;
    logic signed [9:0] s2_exp;
    logic [26:0]       s2_mant;
    logic [31:0]       s2_spec_res;
    logic [2:0]        s2_spec_flags;
    logic [TAG_W-1:0]  s2_tag;

    // ---------------- stage 3: round to nearest even, range check ----------------
    logic              rup;
    logic [24:0]       m25;
    logic [22:0]       frac;
    logic signed [9:0] rexp;
    logic [31:0]       r3;
    logic [2:0]        f3;

    always_comb begin
        rup  = s2_mant[2] & (s2_mant[1] | s2_mant[0] | s2_mant[3]);
        m25  = {1'b0, s2_mant[26:3]} + {24'd0, rup};
        frac = m25[24] ? m25[23:1] : m25[22:0];
        rexp = s2_exp + (m25[24] ? 10'sd1 : 10'sd0);
        r3   = {s2_sign, rexp[7:0], frac};
        f3   = 3'b000;
        if (s2_spec) begin
            r3 = s2_spec_res;
            f3 = s2_spec_flags;
        end else if (s2_zero) begin
            r3 = {s2_sign, 31'd0};
        end else if (rexp >= 10'sd255) begin
            r3 = {s2_sign, 8'hFF, 23'd0};
            f3 = 3'b010;
        end else if (rexp <= 10'sd0) begin
            r3 = {s2_sign, 31'd0};
            f3 = 3'b001;
        end
    end

    logic [EXTRA:0]  pl_valid;
    logic [PW-1:0]   pl_data [0:EXTRA];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_esub       <= 1'b0;
            s1_spec       <= 1'b0;
            s1_exp        <= 8'd0;
            s1_ma         <= 24'd0;
            s1_mb         <= 27'd0;
            s1_spec_res   <= 32'd0;
            s1_spec_flags <= 3'b000;
            s1_tag        <= '0;
            s2_valid      <= 1'b0;
            s2_sign       <= 1'b0;
            s2_zero       <= 1'b0;
            s2_spec       <= 1'b0;
            s2_exp        <= 10'sd0;
            s2_mant       <= 27'd0;
            s2_spec_res   <= 32'd0;
            s2_spec_flags <= 3'b000;
            s2_tag        <= '0;
            pl_valid      <= '0;
            for (int k = 0; k <= EXTRA; k++) pl_data[k] <= '0;
        end else if (adv) begin
            s1_valid      <= accept;
            s1_sign       <= big_s;
            s1_esub       <= big_s ^ sml_s;
            s1_spec       <= spec;
            s1_exp        <= big_e;
            s1_ma         <= big_m;
            s1_mb         <= sml_al;
            s1_spec_res   <= spec_res;
            s1_spec_flags <= spec_flags;
            s1_tag        <= in_tag;
            s2_valid      <= s1_valid;
            s2_sign       <= nsign;
            s2_zero       <= nzero;
            s2_spec       <= s1_spec;
            s2_exp        <= nexp;
            s2_mant       <= norm;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;
            s2_tag        <= s1_tag;
            pl_valid[0]   <= s2_valid;
            pl_data[0]    <= {s2_tag, f3, r3};
            for (int k = 1; k <= EXTRA; k++) begin
                pl_valid[k] <= pl_valid[k-1];
                pl_data[k]  <= pl_data[k-1];
            end
        end
    end

    assign out_valid                   = pl_valid[EXTRA];
    assign {out_tag, out_flags, result} = pl_data[EXTRA];

`ifdef FADD_PIPE_STICKY_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags_sticky <= 3'b000;
        else if (flags_clr)
            flags_sticky <= 3'b000;
        else if (out_valid && out_ready)
            flags_sticky <= flags_sticky | out_flags;
    end
`endif

endmodule

// File: tb/tb_fadd_pipe.sv
// Bench for fadd_pipe: directed plan values plus random ops against a real-arithmetic reference.
// A LATENCY=5 twin receives every accepted op and is checked for result and fixed latency.
module tb_fadd_pipe;

    localparam int TAG_W = 5;
    localparam int LAT   = 3;
    localparam int LAT2  = 5;
    localparam int W     = TAG_W + 3 + 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_sub;
    logic [31:0]      input_a, input_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       out_flags;

    logic             in_valid5, in_ready5, out_valid5;
    logic             out_ready5 = 1'b1;
    logic [31:0]      result5;
    logic [TAG_W-1:0] out_tag5;
    logic [2:0]       out_flags5;

    assign in_valid5 = in_valid & in_ready;

    always #5 clk = ~clk;

`ifdef FADD_PIPE_STICKY_FLAGS_EN
    logic       flags_clr;
    logic [2:0] flags_sticky;
    logic       flags_clr5 = 1'b0;
    logic [2:0] flags_sticky5;
`endif

    fadd_pipe #(.LATENCY(LAT), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sub(in_sub), .input_a(input_a), .input_b(input_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_tag(out_tag), .out_flags(out_flags)
`ifdef FADD_PIPE_STICKY_FLAGS_EN
        , .flags_clr(flags_clr), .flags_sticky(flags_sticky)
`endif
    );

    fadd_pipe #(.LATENCY(LAT2), .TAG_W(TAG_W)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_sub(in_sub), .input_a(input_a), .input_b(input_b), .in_tag(in_tag),
        .out_valid(out_valid5), .out_ready(out_ready5), .result(result5),
        .out_tag(out_tag5), .out_flags(out_flags5)
`ifdef FADD_PIPE_STICKY_FLAGS_EN
        , .flags_clr(flags_clr5), .flags_sticky(flags_sticky5)
`endif
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    logic [W-1:0] exp5_q[$];
    int           acc5_q[$];
    logic         lat_mode = 1'b0;
    logic         use_tab  = 1'b0;
    logic [34:0]  tab_exp  = '0;
    logic [2:0]   sticky_exp = 3'b000;
    logic [TAG_W-1:0] tag_ctr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model: exact sum in double, then RNE to 24 bits ----------------
    function automatic real to_real(input logic s, input logic [7:0] e, input logic [22:0] f);
        logic [63:0] bits;
        if (e == 8'd0) return 0.0;
        bits = {s, 11'(e) + 11'd896, f, 29'd0};
        return $bitstoreal(bits);
    endfunction

    function automatic logic [34:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic        sa, sb;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb, frac;
        real         rs;
        logic [63:0] d;
        logic [52:0] m;
        logic [28:0] rem;
        logic [24:0] m25;
        int          e;
        sa = a[31];      ea = a[30:23]; fa = a[22:0];
        sb = b[31] ^ sub; eb = b[30:23]; fb = b[22:0];
        if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0) ||
            (ea == 8'hFF && eb == 8'hFF && sa != sb))
            return {3'b100, 32'h7FC0_0000};
        if (ea == 8'hFF) return {3'b000, sa, 8'hFF, 23'd0};
        if (eb == 8'hFF) return {3'b000, sb, 8'hFF, 23'd0};
        rs = to_real(sa, ea, fa) + to_real(sb, eb, fb);
        if (rs == 0.0) return {3'b000, (sa == sb) ? sa : 1'b0, 31'd0};
        d   = $realtobits(rs);
        e   = int'(d[62:52]) - 896;
        m   = {1'b1, d[51:0]};
        rem = m[28:0];
        m25 = {1'b0, m[52:29]};
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[29])) m25 = m25 + 25'd1;
        if (m25[24]) begin
            e    = e + 1;
            frac = m25[23:1];
        end else begin
            frac = m25[22:0];
        end
        if (e >= 255) return {3'b010, d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {3'b001, d[63], 31'd0};
        return {3'b000, d[63], 8'(e), frac};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic             held = 1'b0;
    logic [31:0]      h_res;
    logic [TAG_W-1:0] h_tag;
    logic [2:0]       h_flags;

    always @(negedge clk) begin
        logic [W-1:0] e;
        int           l;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                e = use_tab ? {in_tag, tab_exp} : {in_tag, ref_add(input_a, input_b, in_sub)};
                exp_q.push_back(e);
                lat_q.push_back(lat_mode ? cyc : -1);
                exp5_q.push_back(e);
                acc5_q.push_back(cyc);
            end
            if (held) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_result", 64'(result), 64'(h_res));
                check("hold_tag", 64'(out_tag), 64'(h_tag));
                check("hold_flags", 64'(out_flags), 64'(h_flags));
            end
            held    = out_valid && !out_ready;
            h_res   = result;
            h_tag   = out_tag;
            h_flags = out_flags;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got result %h tag %h, none outstanding", result, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    check("result", 64'(result), 64'(e[31:0]));
                    check("tag", 64'(out_tag), 64'(e[W-1:35]));
                    check("flags", 64'(out_flags), 64'(e[34:32]));
                    if (l >= 0) check("latency", 64'(cyc - l), 64'(LAT));
                    sticky_exp = sticky_exp | e[34:32];
                end
            end
            if (out_valid5) begin
                if (exp5_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output5: got result %h tag %h, none outstanding", result5, out_tag5);
                end else begin
                    e = exp5_q.pop_front();
                    l = acc5_q.pop_front();
                    check("result5", 64'(result5), 64'(e[31:0]));
                    check("tag5", 64'(out_tag5), 64'(e[W-1:35]));
                    check("flags5", 64'(out_flags5), 64'(e[34:32]));
                    check("latency5", 64'(cyc - l), 64'(LAT2));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic ok;
        int   n;
        in_valid = 1'b1;
        input_a  = a;
        input_b  = b;
        in_sub   = sub;
        in_tag   = tag_ctr;
        tag_ctr  = tag_ctr + 1'b1;
        n        = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) timeout_fail("send_accept");
        in_valid = 1'b0;
    endtask

    task automatic send_tab(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            input logic [2:0] fl, input logic [31:0] r);
        use_tab = 1'b1;
        tab_exp = {fl, r};
        send(a, b, sub);
        use_tab = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp5_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) timeout_fail("drain");
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       r[30:23] = 8'h00;
            1:       begin r[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) r[22:0] = 23'd0; end
            2:       r[30:23] = 8'($urandom_range(250, 254));
            3:       r[30:23] = 8'($urandom_range(1, 4));
            default: r[30:23] = 8'($urandom_range(100, 154));
        endcase
        return r;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, b;
        logic        done;
        int          n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sub    = 1'b0;
        input_a   = '0;
        input_b   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
`ifdef FADD_PIPE_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_tag", 64'(out_tag), 64'd0);
        check("reset_flags", 64'(out_flags), 64'd0);
`ifdef FADD_PIPE_STICKY_FLAGS_EN
        check("reset_sticky", 64'(flags_sticky), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed plan values, back-to-back, no backpressure, latency measured.
        lat_mode = 1'b1;
        send_tab(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'b000, 32'h4040_0000);
        send_tab(32'h42C8_0000, 32'h4248_0000, 1'b1, 3'b000, 32'h4248_0000);
        send_tab(32'h3F80_0000, 32'h3F80_0000, 1'b1, 3'b000, 32'h0000_0000);
        send_tab(32'h4B80_0000, 32'h3F80_0000, 1'b0, 3'b000, 32'h4B80_0000);
        send_tab(32'h3F80_0000, 32'h33D6_BF95, 1'b0, 3'b000, 32'h3F80_0001);
        send_tab(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 3'b010, 32'h7F80_0000);
        send_tab(32'h7F80_0000, 32'h7F80_0000, 1'b1, 3'b100, 32'h7FC0_0000);
        send_tab(32'h0080_0001, 32'h0080_0000, 1'b1, 3'b001, 32'h0000_0000);
        send_tab(32'h8000_0000, 32'h8000_0000, 1'b0, 3'b000, 32'h8000_0000);
        send_tab(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 3'b100, 32'h7FC0_0000);
        send_tab(32'h7F80_0000, 32'hC2C8_0000, 1'b0, 3'b000, 32'h7F80_0000);
        send_tab(32'h0000_0001, 32'h8000_0000, 1'b0, 3'b000, 32'h0000_0000);
        send_tab(32'hC040_0000, 32'h4000_0000, 1'b0, 3'b000, 32'hBF80_0000);
        send_tab(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b000, 32'h4000_0000);
        drain();
        lat_mode = 1'b0;

`ifdef FADD_PIPE_STICKY_FLAGS_EN
        repeat (3) @(posedge clk);
        #1;
        check("sticky_persist", 64'(flags_sticky), 64'(sticky_exp));
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr  = 1'b0;
        sticky_exp = 3'b000;
        check("sticky_clear", 64'(flags_sticky), 64'(sticky_exp));
`endif

        // Backpressure: four back-to-back ops, output held for five cycles.
        fork
            begin
                for (int i = 0; i < 4; i++) send(rnd_fp(), rnd_fp(), 1'(i & 1));
            end
            begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!out_valid && n < 50);
                if (!out_valid) timeout_fail("stall_wait_valid");
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_out_valid", 64'(out_valid), 64'd1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Random ops with random backpressure and idle gaps.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    a = rnd_fp();
                    if ($urandom_range(0, 2) == 0)
                        b = {1'($urandom_range(0, 1)), a[30:23] - 8'($urandom_range(0, 2)),
                             a[22:0] ^ (23'($urandom) >> $urandom_range(0, 22))};
                    else
                        b = rnd_fp();
                    send(a, b, 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with one op at the output and one behind it.
        out_ready = 1'b0;
        send(32'h4040_0000, 32'h3F80_0000, 1'b0);
        send(32'h4120_0000, 32'h4000_0000, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) timeout_fail("reset_wait_valid");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        check("async_reset_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        lat_q.delete();
        exp5_q.delete();
        acc5_q.delete();
        sticky_exp = 3'b000;
`ifdef FADD_PIPE_STICKY_FLAGS_EN
        check("async_reset_sticky", 64'(flags_sticky), 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("no_stale_out_valid", 64'(out_valid), 64'd0);
            check("no_stale_out_valid5", 64'(out_valid5), 64'd0);
        end
        @(posedge clk);
        #1;
        lat_mode = 1'b1;
        send_tab(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'b000, 32'h4040_0000);
        drain();
        lat_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
